match_id_serializer: RTL and testbench

- Consumer at the output end of the merge-and-intersect stage.
- Accepts one N-slot intersection vector per packet and streams the non-null rule IDs one per beat, in ascending slot order, over a valid/ready interface to the downstream priority/action stage.
- Slot value 0 is the reserved null ID ("no common element"). Non-null slots arrive ascending and distinct because upstream sorting guarantees it.

---
 rtl/classifier_pkg.sv | 28 ++
 rtl/lowest_set_encoder.sv | 33 +++
 rtl/match_id_serializer.sv | 172 +++++++++++++++++
 tb/tb_match_id_serializer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/classifier_pkg.sv
// Shared types and helpers for the match-ID serializer and its encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package classifier_pkg;

    localparam int NUM_SLOTS = 8;
    localparam int LOG_SLOTS = 3;
    localparam int ID_W      = 4;

    // Reserved rule ID meaning "no common element" in a slot.
    localparam logic [ID_W-1:0] NULL_ID = '0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    // Number of set bits in a slot mask.
    function automatic logic [LOG_SLOTS:0] popcount(input logic [NUM_SLOTS-1:0] mask);
        logic [LOG_SLOTS:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            cnt = cnt + {{LOG_SLOTS{1'b0}}, mask[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/lowest_set_encoder.sv
// Finds the lowest set bit of a mask and flags whether more than one bit is set.
// Latency: purely combinational.
// Backpressure: none (no flow control).
module lowest_set_encoder #(
    parameter int N     = 8,
    parameter int LOG_N = 3
) (
    input  logic [N-1:0]     mask_i,
    output logic [LOG_N-1:0] index_o,
    output logic             any_o,
    output logic             multi_o
);

    logic [N-1:0] mask_minus_one;

    // Scan from the top down so the last hit is the lowest index.
    always_comb begin
        index_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                index_o = LOG_N'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    always_comb begin
        mask_minus_one = mask_i - {{(N-1){1'b0}}, 1'b1};
        any_o          = |mask_i;
        multi_o        = |(mask_i & mask_minus_one);
    end

endmodule

// File: rtl/match_id_serializer.sv
// Captures one N-slot intersection vector and streams its non-null IDs one per beat, lowest slot first.
// Latency: first beat 1 cycle after capture; 1 ID/cycle; 1 idle bubble cycle between packets.
// Backpressure: out_ready low holds all beat outputs stable; in_ready is low for the whole packet.
module match_id_serializer
    import classifier_pkg::*;
#(
    parameter int N      = NUM_SLOTS,
    parameter int LOG_N  = LOG_SLOTS,
    parameter int ELEM_W = ID_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*ELEM_W-1:0] in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ELEM_W-1:0]   out_id,
    output logic                out_last,
    output logic                out_empty,
    output logic [LOG_N:0]      out_count
);

    state_e              state_q, state_d;
    logic [N*ELEM_W-1:0] buf_q, buf_d;
    logic [N-1:0]        pend_q, pend_d;

    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [ELEM_W-1:0]   out_id_q, out_id_d;
    logic                out_last_q, out_last_d;
    logic                out_empty_q, out_empty_d;
    logic [LOG_N:0]      out_count_q, out_count_d;

    logic                capture;
    logic                beat_done;
    logic [LOG_N-1:0]    nxt_idx;
    logic                nxt_any;
    logic                nxt_multi;
    logic [ELEM_W-1:0]   nxt_slot;

    assign capture   = (state_q == ST_IDLE) && in_valid && in_ready_q;
    assign beat_done = (state_q == ST_SEND) && out_valid_q && out_ready;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave IDLE on capture, return once the final beat is accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (capture) state_d = ST_SEND;
            ST_SEND: if (beat_done && out_last_q) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Slot buffer and pending mask: load on capture, drop the lowest pending slot per accepted beat.
    always_comb begin
        buf_d  = buf_q;
        pend_d = pend_q;
        if (capture) begin
            buf_d = in;
            for (int i = 0; i < N; i++) begin
                pend_d[i] = (in[i*ELEM_W +: ELEM_W] != NULL_ID);
            end
        end else if (beat_done) begin
            pend_d = pend_q & (pend_q - {{(N-1){1'b0}}, 1'b1});
        end
    end

    // The encoder looks at the post-update mask so the registered outputs show the upcoming beat.
    lowest_set_encoder #(
        .N     (N),
        .LOG_N (LOG_N)
    ) u_enc (
        .mask_i  (pend_d),
        .index_o (nxt_idx),
        .any_o   (nxt_any),
        .multi_o (nxt_multi)
    );

    // Pick the slot addressed by the encoder out of the (possibly just loaded) buffer.
    always_comb begin
        nxt_slot = NULL_ID;
        for (int i = 0; i < N; i++) begin
            if (nxt_idx == LOG_N'(i)) begin
                nxt_slot = buf_d[i*ELEM_W +: ELEM_W];
            end
        end
    end

    // Output next-values; everything holds unless a capture or an accepted beat happens.
    always_comb begin
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        out_last_d  = out_last_q;
        out_empty_d = out_empty_q;
        out_count_d = out_count_q;
        case (state_q)
            ST_IDLE: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                if (capture) begin
                    in_ready_d  = 1'b0;
                    out_valid_d = 1'b1;
                    out_id_d    = nxt_any ? nxt_slot : NULL_ID;
                    out_last_d  = ~nxt_multi;
                    out_empty_d = ~nxt_any;
                    out_count_d = popcount(pend_d);
                end
            end
            ST_SEND: begin
                if (beat_done) begin
                    if (out_last_q) begin
                        in_ready_d  = 1'b1;
                        out_valid_d = 1'b0;
                        out_id_d    = NULL_ID;
                        out_last_d  = 1'b0;
                        out_empty_d = 1'b0;
                        out_count_d = '0;
                    end else begin
                        out_id_d   = nxt_slot;
                        out_last_d = ~nxt_multi;
                    end
                end
            end
            default: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset discards any packet in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q       <= '0;
            pend_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_id_q    <= NULL_ID;
            out_last_q  <= 1'b0;
            out_empty_q <= 1'b0;
            out_count_q <= '0;
        end else begin
            buf_q       <= buf_d;
            pend_q      <= pend_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_last_q  <= out_last_d;
            out_empty_q <= out_empty_d;
            out_count_q <= out_count_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out_last  = out_last_q;
    assign out_empty = out_empty_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_match_id_serializer.sv
// Directed and randomized bench for match_id_serializer against a queue-based reference model.
// Latency: checks 1-cycle capture-to-beat, 1 ID/cycle and the 1-cycle inter-packet bubble.
// Backpressure: drives steady, patterned and random out_ready.
module tb_match_id_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_v;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_id;
    logic        out_last;
    logic        out_empty;
    logic [3:0]  out_count;

    int checks = 0;
    int errors = 0;

    match_id_serializer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_v),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_last  (out_last),
        .out_empty (out_empty),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Slot i lives at bits [i*4 +: 4].
    function automatic logic [31:0] mk(input int a0, input int a1, input int a2, input int a3,
                                       input int a4, input int a5, input int a6, input int a7);
        return {a7[3:0], a6[3:0], a5[3:0], a4[3:0], a3[3:0], a2[3:0], a1[3:0], a0[3:0]};
    endfunction

    // rmode: 0 = always ready, 1 = ready on every third cycle, 2 = random.
    task automatic send_pkt(input string name, input logic [31:0] vec, input int rmode,
                            input bit hold_other, input logic [31:0] other);
        int  exp_q[$];
        int  cnt;
        int  idx;
        int  cyc;
        bit  got;
        bit  done;
        logic [3:0] s;
        for (int i = 0; i < 8; i++) begin
            s = vec[i*4 +: 4];
            if (s != 4'd0) exp_q.push_back(int'(s));
        end
        cnt = exp_q.size();
        if (cnt == 0) exp_q.push_back(0);

        got = 1'b0;
        for (int w = 0; w < 20 && !got; w++) begin
            if (in_ready) got = 1'b1;
            else tick();
        end
        chk({name, ":in_ready_wait"}, got, 1);
        if (!got) return;

        in_valid = 1'b1;
        in_v     = vec;
        tick();
        if (hold_other) in_v = other;
        else in_valid = 1'b0;
        chk({name, ":first_beat_latency"}, out_valid, 1);

        idx  = 0;
        done = 1'b0;
        for (cyc = 0; cyc < 200 && !done; cyc++) begin
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            chk({name, ":out_valid"}, out_valid, 1);
            chk({name, ":in_ready_busy"}, in_ready, 0);
            chk({name, ":out_id"}, out_id, exp_q[idx]);
            chk({name, ":out_last"}, out_last, (idx == exp_q.size() - 1));
            chk({name, ":out_empty"}, out_empty, (cnt == 0));
            chk({name, ":out_count"}, out_count, cnt);
            tick();
            if (out_ready) begin
                if (idx == exp_q.size() - 1) done = 1'b1;
                idx++;
            end
        end
        chk({name, ":packet_completed"}, done, 1);
        if (rmode == 0) chk({name, ":beat_cycles"}, cyc, exp_q.size());
        chk({name, ":bubble_valid_low"}, out_valid, 0);
        chk({name, ":bubble_in_ready"}, in_ready, 1);
    endtask

    initial begin
        logic [31:0] v;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_v      = '0;
        out_ready = 1'b0;
        tick();
        chk("rst:in_ready", in_ready, 1);
        chk("rst:out_valid", out_valid, 0);
        chk("rst:out_id", out_id, 0);
        chk("rst:out_last", out_last, 0);
        chk("rst:out_empty", out_empty, 0);
        chk("rst:out_count", out_count, 0);
        #2 reset = 1'b0;
        tick();

        send_pkt("sparse", mk(0, 3, 0, 5, 0, 0, 9, 0), 0, 1'b0, '0);
        send_pkt("empty", '0, 0, 1'b0, '0);
        send_pkt("full_stall", mk(1, 2, 3, 4, 5, 6, 7, 8), 1, 1'b0, '0);

        // Second vector held on the input during SEND must wait for IDLE.
        send_pkt("hold_a", mk(0, 0, 12, 0, 0, 0, 0, 13), 0, 1'b1, mk(14, 0, 0, 0, 0, 0, 0, 1));
        send_pkt("hold_b", mk(14, 0, 0, 0, 0, 0, 0, 1), 0, 1'b0, '0);

        // Asynchronous reset after the second of three beats.
        in_valid = 1'b1;
        in_v     = mk(4, 0, 6, 0, 0, 0, 0, 11);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("arst:beat1", out_id, 4);
        tick();
        chk("arst:beat2", out_id, 6);
        tick();
        chk("arst:beat3_pending", out_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst:out_valid", out_valid, 0);
        chk("arst:out_id", out_id, 0);
        chk("arst:out_last", out_last, 0);
        chk("arst:out_count", out_count, 0);
        chk("arst:in_ready", in_ready, 1);
        #1 reset = 1'b0;
        tick();
        send_pkt("after_rst", mk(7, 0, 0, 0, 0, 0, 0, 0), 0, 1'b0, '0);

        send_pkt("b2b_one", mk(2, 0, 0, 0, 0, 0, 0, 0), 0, 1'b0, '0);
        send_pkt("b2b_empty", '0, 0, 1'b0, '0);

        for (int p = 0; p < 25; p++) begin
            v = '0;
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 1) == 1) v[i*4 +: 4] = 4'($urandom_range(1, 15));
            end
            send_pkt("random", v, 2, 1'b0, '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
